// File: rtl/pic_interrupt_engine.sv
// PIC interrupt engine: IRR/ISR tracking, rotating priority,
// two-pulse INTA acknowledge and EOI / priority commands.
module pic_interrupt_engine #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_triggered,
  input  logic [NUM_IRQ-1:0] interrupt_mask,
  input  logic               special_fully_nested,
  input  logic               auto_eoi,
  input  logic               rotate_on_aeoi,
  input  logic               int_ack,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_level,
  input  logic               eoi_rotate,
  input  logic               set_prio_valid,
  input  logic [ID_W-1:0]    set_prio_level,
  output logic               int_out,
  output logic               vector_valid,
  output logic [ID_W-1:0]    vector_id,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    lowest_prio
);

  typedef enum logic {IDLE, ACK1} state_t;

  localparam logic [ID_W:0]   NONE = (ID_W+1)'(NUM_IRQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_IRQ-1);

  state_t             state;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] irr_n;
  logic [NUM_IRQ-1:0] isr_n;
  logic [ID_W-1:0]    ack_id;
  logic [ID_W-1:0]    lp_n;
  logic [ID_W-1:0]    win_lvl;
  logic [ID_W-1:0]    top_lvl;
  logic [ID_W-1:0]    eoi_lvl;
  logic [ID_W:0]      win_rank;
  logic [ID_W:0]      top_rank;
  logic               spurious;
  logic               win_ok;
  logic               ack1;
  logic               ack2;
  logic               aeoi_clr;
  logic               eoi_hit;

  // Rank 0 is the level just after lowest_prio; NONE when v is empty.
  function automatic logic [ID_W:0] best_rank(
    input logic [NUM_IRQ-1:0] v,
    input logic [ID_W-1:0]    lp
  );
    logic [ID_W:0]   r;
    logic [ID_W-1:0] lvl;
    r = NONE;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      lvl = lp + ID_W'(1) + ID_W'(k);
      if (v[lvl]) r = (ID_W+1)'(k);
    end
    return r;
  endfunction

  always_comb begin
    cand     = irr & ~interrupt_mask;
    win_rank = best_rank(cand, lowest_prio);
    top_rank = best_rank(isr, lowest_prio);
    win_lvl  = lowest_prio + ID_W'(1) + win_rank[ID_W-1:0];
    top_lvl  = lowest_prio + ID_W'(1) + top_rank[ID_W-1:0];
    win_ok   = (win_rank < top_rank) ||
               (special_fully_nested && win_rank == top_rank &&
                win_rank != NONE);
    ack1     = int_ack && state == IDLE;
    ack2     = int_ack && state == ACK1;
    aeoi_clr = ack2 && auto_eoi && !spurious;
    eoi_hit  = eoi_valid && (eoi_specific || top_rank != NONE);
    eoi_lvl  = eoi_specific ? eoi_level : top_lvl;

    irr_n = level_triggered ? irq_in : (irr | (irq_in & ~prev));
    if (ack1 && win_ok) irr_n[win_lvl] = 1'b0;

    // EOI and AEOI clears land before the ACK1 set of the same cycle.
    isr_n = isr;
    if (eoi_hit) isr_n[eoi_lvl] = 1'b0;
    if (aeoi_clr) isr_n[ack_id] = 1'b0;
    if (ack1 && win_ok) isr_n[win_lvl] = 1'b1;

    lp_n = lowest_prio;
    if (aeoi_clr && rotate_on_aeoi) lp_n = ack_id;
    if (eoi_hit && eoi_rotate) lp_n = eoi_lvl;
    if (set_prio_valid) lp_n = set_prio_level;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      prev         <= '0;
      irr          <= '0;
      isr          <= '0;
      lowest_prio  <= LAST;
      ack_id       <= '0;
      spurious     <= 1'b0;
      int_out      <= 1'b0;
      vector_valid <= 1'b0;
      vector_id    <= '0;
    end else begin
      prev         <= irq_in;
      irr          <= irr_n;
      isr          <= isr_n;
      lowest_prio  <= lp_n;
      vector_valid <= 1'b0;
      int_out      <= win_ok && !ack2 && !vector_valid;
      unique case (state)
        IDLE: begin
          if (int_ack) begin
            state    <= ACK1;
            ack_id   <= win_ok ? win_lvl : LAST;
            spurious <= !win_ok;
          end
        end
        ACK1: begin
          if (int_ack) begin
            state        <= IDLE;
            vector_valid <= 1'b1;
            vector_id    <= ack_id;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_interrupt_engine.sv
// Bench for pic_interrupt_engine: directed scenarios plus a random
// run against a rank-based reference model (8-line instance).
module tb_pic_interrupt_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        level_triggered, sfnm, auto_eoi, rotate_on_aeoi;
  logic        int_ack, eoi_valid, eoi_specific, eoi_rotate;
  logic        set_prio_valid;

  logic [7:0]  irq8, mask8, irr8, isr8;
  logic [2:0]  eoi_level8, set_prio_level8, vid8, lp8;
  logic        int8, vv8;

  logic [15:0] irq16, mask16, irr16, isr16;
  logic [3:0]  eoi_level16, set_prio_level16, vid16, lp16;
  logic        int16, vv16;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  pic_interrupt_engine #(.NUM_IRQ(8)) u8 (
    .clock(clock), .reset(reset), .irq_in(irq8),
    .level_triggered(level_triggered), .interrupt_mask(mask8),
    .special_fully_nested(sfnm), .auto_eoi(auto_eoi),
    .rotate_on_aeoi(rotate_on_aeoi), .int_ack(int_ack),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level8), .eoi_rotate(eoi_rotate),
    .set_prio_valid(set_prio_valid), .set_prio_level(set_prio_level8),
    .int_out(int8), .vector_valid(vv8), .vector_id(vid8),
    .irr(irr8), .isr(isr8), .lowest_prio(lp8)
  );

  pic_interrupt_engine #(.NUM_IRQ(16)) u16 (
    .clock(clock), .reset(reset), .irq_in(irq16),
    .level_triggered(level_triggered), .interrupt_mask(mask16),
    .special_fully_nested(sfnm), .auto_eoi(auto_eoi),
    .rotate_on_aeoi(rotate_on_aeoi), .int_ack(int_ack),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level16), .eoi_rotate(eoi_rotate),
    .set_prio_valid(set_prio_valid), .set_prio_level(set_prio_level16),
    .int_out(int16), .vector_valid(vv16), .vector_id(vid16),
    .irr(irr16), .isr(isr16), .lowest_prio(lp16)
  );

  // Reference model state for the 8-line instance.
  bit [7:0] m_irr, m_isr, m_prev;
  int       m_lp, m_ack, m_vid;
  bit       m_busy, m_spur, m_int, m_vv;

  function automatic int rank(int lvl, int lp);
    return (lvl - lp + 7) % 8;
  endfunction

  task automatic tick();
    bit [7:0] cand, n_irr, n_isr;
    int n_lp, n_ack, n_vid, wr, ir, wl, tl;
    bit n_busy, n_spur, n_int, n_vv, win, a1, a2;
    if (reset) begin
      n_irr = 0; n_isr = 0; n_lp = 7; n_busy = 0; n_ack = 0;
      n_spur = 0; n_int = 0; n_vv = 0; n_vid = 0;
    end else begin
      cand = m_irr & ~mask8;
      wr = 8; ir = 8; wl = 0; tl = 0;
      for (int l = 0; l < 8; l++) begin
        if (cand[l] && rank(l, m_lp) < wr) begin
          wr = rank(l, m_lp); wl = l;
        end
        if (m_isr[l] && rank(l, m_lp) < ir) begin
          ir = rank(l, m_lp); tl = l;
        end
      end
      win = (wr < ir) || (sfnm && wr == ir && wr < 8);
      a1 = int_ack && !m_busy;
      a2 = int_ack && m_busy;
      for (int l = 0; l < 8; l++)
        n_irr[l] = level_triggered ? irq8[l]
                                   : (m_irr[l] | (irq8[l] & !m_prev[l]));
      if (a1 && win) n_irr[wl] = 0;
      n_isr = m_isr;
      n_lp = m_lp;
      if (a2 && auto_eoi && !m_spur) begin
        n_isr[m_ack] = 0;
        if (rotate_on_aeoi) n_lp = m_ack;
      end
      if (eoi_valid) begin
        if (eoi_specific) begin
          n_isr[eoi_level8] = 0;
          if (eoi_rotate) n_lp = int'(eoi_level8);
        end else if (ir < 8) begin
          n_isr[tl] = 0;
          if (eoi_rotate) n_lp = tl;
        end
      end
      if (a1 && win) n_isr[wl] = 1;
      if (set_prio_valid) n_lp = int'(set_prio_level8);
      n_int = win && !a2 && !m_vv;
      n_vv = a2;
      n_vid = a2 ? m_ack : m_vid;
      n_busy = a1 ? 1'b1 : (a2 ? 1'b0 : m_busy);
      n_ack = a1 ? (win ? wl : 7) : m_ack;
      n_spur = a1 ? !win : m_spur;
    end
    @(posedge clock);
    #1;
    m_irr = n_irr; m_isr = n_isr; m_lp = n_lp; m_prev = reset ? 8'h00 : irq8;
    m_busy = n_busy; m_ack = n_ack; m_spur = n_spur;
    m_int = n_int; m_vv = n_vv; m_vid = n_vid;
  endtask

  task automatic clear_inputs();
    level_triggered = 0; sfnm = 0; auto_eoi = 0; rotate_on_aeoi = 0;
    int_ack = 0; eoi_valid = 0; eoi_specific = 0; eoi_rotate = 0;
    set_prio_valid = 0;
    irq8 = 0; mask8 = 0; eoi_level8 = 0; set_prio_level8 = 0;
    irq16 = 0; mask16 = 0; eoi_level16 = 0; set_prio_level16 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic ack_pair();
    int_ack = 1; tick(); int_ack = 0; tick();
    int_ack = 1; tick(); int_ack = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (irr8 !== 8'h00) $display("FAIL rst_irr got=%h exp=00", irr8); else passes++;
    checks++; if (isr8 !== 8'h00) $display("FAIL rst_isr got=%h exp=00", isr8); else passes++;
    checks++; if (lp8 !== 3'd7) $display("FAIL rst_lp got=%0d exp=7", lp8); else passes++;
    checks++; if (int8 !== 1'b0 || vv8 !== 1'b0) $display("FAIL rst_out int=%b vv=%b exp=0/0", int8, vv8); else passes++;
    checks++; if (vid8 !== 3'd0) $display("FAIL rst_vid got=%0d exp=0", vid8); else passes++;
    checks++; if (lp16 !== 4'd15) $display("FAIL rst_lp16 got=%0d exp=15", lp16); else passes++;
  endtask

  task automatic test_edge_nesting();
    do_reset();
    irq8 = 8'h28; tick();
    checks++; if (irr8 !== 8'h28 || int8 !== 1'b0) $display("FAIL edge_irr irr=%h int=%b exp=28/0", irr8, int8); else passes++;
    irq8 = 8'h00; tick();
    checks++; if (int8 !== 1'b1) $display("FAIL edge_int got=%b exp=1", int8); else passes++;
    int_ack = 1; tick(); int_ack = 0;
    checks++; if (isr8 !== 8'h08 || irr8 !== 8'h20) $display("FAIL ack1_regs isr=%h irr=%h exp=08/20", isr8, irr8); else passes++;
    tick();
    int_ack = 1; tick(); int_ack = 0;
    checks++; if (vv8 !== 1'b1 || vid8 !== 3'd3) $display("FAIL ack2_vec vv=%b id=%0d exp=1/3", vv8, vid8); else passes++;
    tick(); tick();
    checks++; if (int8 !== 1'b0 || vv8 !== 1'b0) $display("FAIL nest_block int=%b vv=%b exp=0/0", int8, vv8); else passes++;
    eoi_valid = 1; tick(); eoi_valid = 0;
    checks++; if (isr8 !== 8'h00) $display("FAIL ns_eoi isr=%h exp=00", isr8); else passes++;
    tick();
    checks++; if (int8 !== 1'b1) $display("FAIL post_eoi_int got=%b exp=1", int8); else passes++;
  endtask

  task automatic test_eoi_rotate();
    do_reset();
    eoi_valid = 1; eoi_specific = 1; eoi_level8 = 3'd4; eoi_rotate = 1;
    tick();
    eoi_valid = 0; eoi_specific = 0; eoi_rotate = 0;
    checks++; if (lp8 !== 3'd4) $display("FAIL eoi_rot_lp got=%0d exp=4", lp8); else passes++;
    irq8 = 8'h44; tick(); irq8 = 8'h00; tick();
    ack_pair();
    checks++; if (vv8 !== 1'b1 || vid8 !== 3'd6) $display("FAIL rot_order vv=%b id=%0d exp=1/6", vv8, vid8); else passes++;
    checks++; if (isr8 !== 8'h40 || irr8 !== 8'h04) $display("FAIL rot_regs isr=%h irr=%h exp=40/04", isr8, irr8); else passes++;
  endtask

  task automatic test_aeoi_rotate();
    do_reset();
    auto_eoi = 1; rotate_on_aeoi = 1;
    irq8 = 8'h01; tick(); irq8 = 8'h00; tick();
    ack_pair();
    checks++; if (vv8 !== 1'b1 || vid8 !== 3'd0) $display("FAIL aeoi_vec vv=%b id=%0d exp=1/0", vv8, vid8); else passes++;
    checks++; if (isr8 !== 8'h00 || lp8 !== 3'd0) $display("FAIL aeoi_regs isr=%h lp=%0d exp=00/0", isr8, lp8); else passes++;
    irq8 = 8'h81; tick(); irq8 = 8'h00; tick(); tick();
    ack_pair();
    checks++; if (vid8 !== 3'd7 || irr8 !== 8'h01) $display("FAIL aeoi_order id=%0d irr=%h exp=7/01", vid8, irr8); else passes++;
  endtask

  task automatic test_sfnm();
    do_reset();
    sfnm = 1;
    irq8 = 8'h04; tick(); irq8 = 8'h00; tick();
    ack_pair();
    checks++; if (isr8 !== 8'h04) $display("FAIL sfnm_isr got=%h exp=04", isr8); else passes++;
    irq8 = 8'h04; tick(); irq8 = 8'h00; tick(); tick();
    checks++; if (int8 !== 1'b1) $display("FAIL sfnm_int got=%b exp=1", int8); else passes++;
    ack_pair();
    checks++; if (vid8 !== 3'd2 || isr8 !== 8'h04 || irr8 !== 8'h00) $display("FAIL sfnm_nest id=%0d isr=%h irr=%h exp=2/04/00", vid8, isr8, irr8); else passes++;
    do_reset();
    irq8 = 8'h04; tick(); irq8 = 8'h00; tick();
    ack_pair();
    irq8 = 8'h04; tick(); irq8 = 8'h00; tick(); tick();
    checks++; if (int8 !== 1'b0 || irr8 !== 8'h04) $display("FAIL fnm_block int=%b irr=%h exp=0/04", int8, irr8); else passes++;
  endtask

  task automatic test_spurious();
    do_reset();
    mask8 = 8'hFF; irq8 = 8'h02; tick(); tick();
    checks++; if (int8 !== 1'b0) $display("FAIL mask_int got=%b exp=0", int8); else passes++;
    ack_pair();
    checks++; if (vv8 !== 1'b1 || vid8 !== 3'd7) $display("FAIL spur_vec vv=%b id=%0d exp=1/7", vv8, vid8); else passes++;
    checks++; if (isr8 !== 8'h00 || irr8[1] !== 1'b1) $display("FAIL spur_regs isr=%h irr=%h exp=00/x2", isr8, irr8); else passes++;
  endtask

  task automatic test_level16();
    do_reset();
    level_triggered = 1;
    irq16 = 16'h1000; tick();
    checks++; if (irr16 !== 16'h1000) $display("FAIL lvl_set irr=%h exp=1000", irr16); else passes++;
    tick();
    checks++; if (int16 !== 1'b1) $display("FAIL lvl_int got=%b exp=1", int16); else passes++;
    irq16 = 16'h0000; tick();
    checks++; if (irr16 !== 16'h0000) $display("FAIL lvl_clr irr=%h exp=0000", irr16); else passes++;
    tick();
    checks++; if (int16 !== 1'b0) $display("FAIL lvl_drop int=%b exp=0", int16); else passes++;
    irq16 = 16'h1000; tick(); tick();
    int_ack = 1; tick(); int_ack = 0;
    checks++; if (isr16 !== 16'h1000) $display("FAIL lvl_ack1 isr=%h exp=1000", isr16); else passes++;
    reset = 1; tick(); reset = 0;
    checks++; if (irr16 !== 16'h0 || isr16 !== 16'h0 || lp16 !== 4'd15) $display("FAIL mid_rst irr=%h isr=%h lp=%0d exp=0/0/15", irr16, isr16, lp16); else passes++;
    checks++; if (int16 !== 1'b0 || vv16 !== 1'b0 || vid16 !== 4'd0) $display("FAIL mid_rst_out int=%b vv=%b id=%0d exp=0/0/0", int16, vv16, vid16); else passes++;
    irq16 = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (vv16 !== 1'b0) $display("FAIL mid_rst_vv cyc=%0d got=%b exp=0", i, vv16); else passes++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      level_triggered = 1'(seg);
      sfnm = 1'($urandom);
      auto_eoi = 1'($urandom);
      rotate_on_aeoi = 1'($urandom);
      for (int c = 0; c < 150; c++) begin
        reset = ($urandom_range(0, 99) == 0);
        irq8 = 8'($urandom) & 8'($urandom);
        mask8 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        int_ack = ($urandom_range(0, 3) == 0);
        eoi_valid = ($urandom_range(0, 7) == 0);
        eoi_specific = 1'($urandom);
        eoi_rotate = 1'($urandom);
        eoi_level8 = 3'($urandom);
        set_prio_valid = ($urandom_range(0, 31) == 0);
        set_prio_level8 = 3'($urandom);
        tick();
        checks++; if (irr8 !== m_irr) $display("FAIL rnd_irr s=%0d c=%0d got=%h exp=%h", seg, c, irr8, m_irr); else passes++;
        checks++; if (isr8 !== m_isr) $display("FAIL rnd_isr s=%0d c=%0d got=%h exp=%h", seg, c, isr8, m_isr); else passes++;
        checks++; if (lp8 !== 3'(m_lp)) $display("FAIL rnd_lp s=%0d c=%0d got=%0d exp=%0d", seg, c, lp8, m_lp); else passes++;
        checks++; if (int8 !== m_int) $display("FAIL rnd_int s=%0d c=%0d got=%b exp=%b", seg, c, int8, m_int); else passes++;
        checks++; if (vv8 !== m_vv) $display("FAIL rnd_vv s=%0d c=%0d got=%b exp=%b", seg, c, vv8, m_vv); else passes++;
        checks++; if (vid8 !== 3'(m_vid)) $display("FAIL rnd_vid s=%0d c=%0d got=%0d exp=%0d", seg, c, vid8, m_vid); else passes++;
      end
    end
    reset = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_edge_nesting();
    test_eoi_rotate();
    test_aeoi_rotate();
    test_sfnm();
    test_spurious();
    test_level16();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pic_interrupt_engine.md
Name: pic_interrupt_engine

Overview:
Parametrised interrupt request/service engine for the PIC family. It registers interrupt requests (IRR) and in-service state (ISR), resolves priority with rotation and nesting modes, and runs the two-pulse INTA acknowledge sequence that returns a vector ID. It also executes EOI and priority commands decoded upstream by the control-word logic, and sits between the IR pin synchroniser and the data-bus/cascade logic.

Parameters:
NUM_IRQ, 8, number of interrupt lines; power of two, 2..32
ID_W, $clog2(NUM_IRQ), width of level/vector IDs

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
irq_in  in  NUM_IRQ  synchronised IR lines
level_triggered  in  1  1 = level mode, 0 = rising-edge mode
interrupt_mask  in  NUM_IRQ  IMR; 1 masks the line
special_fully_nested  in  1  SFNM enable
auto_eoi  in  1  AEOI mode enable
rotate_on_aeoi  in  1  rotate priority on automatic EOI
int_ack  in  1  one-cycle pulse per INTA edge
eoi_valid  in  1  one-cycle EOI command strobe
eoi_specific  in  1  1 = specific EOI, 0 = non-specific
eoi_level  in  ID_W  level for specific EOI
eoi_rotate  in  1  rotate priority with this EOI
set_prio_valid  in  1  set-priority command strobe
set_prio_level  in  ID_W  new lowest-priority level
int_out  out  1  interrupt request to CPU (INT)
vector_valid  out  1  one-cycle pulse; vector_id valid
vector_id  out  ID_W  acknowledged level
irr  out  NUM_IRQ  interrupt request register
isr  out  NUM_IRQ  in-service register
lowest_prio  out  ID_W  current lowest-priority level

Behaviour:
- Reset: irr=0, isr=0, lowest_prio=NUM_IRQ-1 (level 0 highest), int_out=0, vector_valid=0, vector_id=0, FSM=IDLE, edge history=0.
- IRR per bit: edge mode: set on irq_in 0->1 (registered previous sample); level mode: set while irq_in=1, cleared when irq_in=0. Cleared when the bit is selected at ACK1. Set beats level-clear only in edge mode; the ACK1 clear beats a same-cycle set.
- Priority order: highest = lowest_prio+1 (mod NUM_IRQ), increasing cyclically. Candidate = irr & ~interrupt_mask. Winner = highest-priority candidate strictly above the highest-priority ISR bit. In SFNM, the same level as the highest ISR bit also qualifies.
- int_out: registered, 1 cycle after a winner exists; drops during ACK2 and the cycle after vector_valid; re-evaluated afterwards.
- FSM IDLE -> ACK1 on int_ack: latch winner in ack_id, set isr[ack_id], clear irr[ack_id]. If there is no winner, the acknowledge is spurious: ack_id=NUM_IRQ-1, isr unchanged.
- ACK1 -> IDLE on the second int_ack: vector_id=ack_id and vector_valid=1 for exactly one cycle. If auto_eoi and not spurious, clear isr[ack_id] in the same cycle. If rotate_on_aeoi is also set, lowest_prio=ack_id.
- int_ack pulses in IDLE with int_out=0 still follow the spurious path.
- EOI (eoi_valid): non-specific clears the highest-priority ISR bit (no-op if isr=0); specific clears isr[eoi_level]. With eoi_rotate, lowest_prio=cleared level (non-specific with isr=0 does not rotate).
- set_prio_valid: lowest_prio=set_prio_level. If it coincides with an EOI rotate, set_prio wins.
- Same-cycle EOI and ACK1: EOI clear applies first, then the ACK1 set. The winner uses pre-EOI isr.
- All arithmetic is modulo NUM_IRQ (ID_W-bit wrap).
- reset mid-sequence: returns to IDLE, no vector_valid emitted.

Test Plan:
- NUM_IRQ=8, edge mode, irq_in[3] and [5] pulsed together, two int_ack pulses -> int_out=1 one cycle later; after ACK1 isr=8'h08, irr=8'h20; vector_valid with vector_id=3; int_out stays 0 (5 below 3), non-specific EOI clears isr, then int_out=1 for 5.
- Specific EOI with eoi_rotate, level 4 -> lowest_prio=4; then irq 2 and 6 simultaneously -> vector_id=6 acknowledged first.
- auto_eoi=1, rotate_on_aeoi=1, irq 0 acked -> isr stays 0 at vector_valid, lowest_prio=0; a new irq 0 now has lowest priority vs irq 7.
- SFNM=1, isr[2] set, irq 2 reasserted -> int_out=1, nested ack sets isr[2] again. With SFNM=0 -> int_out stays 0.
- Masking and spurious: interrupt_mask=8'hFF, irq 1 high, int_ack x2 -> vector_id=7, isr=0, irr[1] still 1.
- NUM_IRQ=16, level mode, irq 12 held then dropped before ack -> irr[12] clears, int_out drops; reset asserted between ACK1 and ACK2 -> all outputs return to reset values, no vector_valid.
